// File: rtl/signed_divider_seq.sv
// Sequential 8-bit / 4-bit signed restoring divider: start -> done in 9 cycles.
// Optional macro DIVZERO_CHECK_EN: a zero divisor completes immediately with dz=1.
module signed_divider_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic [7:0] quot,
   output logic [3:0] rem,
   output logic       busy,
   output logic       done,
   output logic       dz,
   output logic       ovf
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

   state_t     r_state;
   logic [2:0] r_cnt;
   logic [7:0] r_dividend;
   logic [3:0] r_divisor;
   logic [7:0] r_q;        // dividend magnitude shifts out as quotient bits shift in
   logic [3:0] r_part;     // settled partial remainder, always < |divisor| <= 8
   logic [3:0] r_dmag;

   logic [4:0] w_shift;    // 5-bit trial value so |divisor|=8 compares without loss
   logic       w_fits;
   logic [3:0] w_trial;
   logic [7:0] w_quot_fix;
   logic [3:0] w_rem_fix;
   logic       w_ovf;
   logic       w_zero_div;

   function automatic logic [7:0] abs8(input logic [7:0] v);
      abs8 = v[7] ? (8'd0 - v) : v;
   endfunction

   function automatic logic [3:0] abs4(input logic [3:0] v);
      abs4 = v[3] ? (4'd0 - v) : v;
   endfunction

   assign w_shift    = {r_part, r_q[7]};
   assign w_fits     = (w_shift >= {1'b0, r_dmag});
   assign w_trial    = w_shift[3:0] - r_dmag;
   assign w_quot_fix = (r_dividend[7] ^ r_divisor[3]) ? (8'd0 - r_q) : r_q;
   assign w_rem_fix  = r_dividend[7] ? (4'd0 - r_part) : r_part;
   assign w_ovf      = (r_dividend == 8'h80) && (r_divisor == 4'hF);

`ifdef DIVZERO_CHECK_EN
   assign w_zero_div = (divisor == 4'h0);
`else
   assign w_zero_div = 1'b0;
`endif

   // Control FSM, restoring datapath and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= 3'd0;
         r_dividend <= 8'h00;
         r_divisor  <= 4'h0;
         r_q        <= 8'h00;
         r_part     <= 4'h0;
         r_dmag     <= 4'h0;
         quot       <= 8'h00;
         rem        <= 4'h0;
         busy       <= 1'b0;
         done       <= 1'b0;
         dz         <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && w_zero_div) begin
                  quot <= 8'hFF;
                  rem  <= 4'h0;
                  dz   <= 1'b1;
                  ovf  <= 1'b0;
                  done <= 1'b1;
               end else if (start) begin
                  r_dividend <= dividend;
                  r_divisor  <= divisor;
                  r_q        <= abs8(dividend);
                  r_dmag     <= abs4(divisor);
                  r_part     <= 4'h0;
                  r_cnt      <= 3'd0;
                  busy       <= 1'b1;
                  r_state    <= CALC;
               end else begin
                  r_state <= IDLE;
               end
            end
            CALC: begin
               r_part <= w_fits ? w_trial : w_shift[3:0];
               r_q    <= {r_q[6:0], w_fits};
               r_cnt  <= r_cnt + 3'd1;
               if (r_cnt == 3'd7) begin
                  r_state <= FIX;
               end else begin
                  r_state <= CALC;
               end
            end
            FIX: begin
               quot    <= w_quot_fix;
               rem     <= w_rem_fix;
               ovf     <= w_ovf;
               dz      <= 1'b0;
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/signed_divider_seq.md
SIGNED_DIVIDER_SEQ -- requirements
Module: signed_divider_seq

Interface
REQ-001 Parameters: none; all operand and result widths are fixed as listed below.
REQ-002 clk  input  1  single clock for all state; every register updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  8  signed two's-complement dividend.
REQ-006 divisor  input  4  signed two's-complement divisor.
REQ-007 quot  output  8  signed quotient, registered.
REQ-008 rem  output  4  signed remainder, registered.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when quot/rem become valid.
REQ-011 dz  output  1  divide-by-zero flag, registered with done.
REQ-012 ovf  output  1  quotient-overflow flag, registered with done.

Function
REQ-013 Role: sequential signed divider; inverse of the team's signed 4x4 multiplier (dividend = quot*divisor + rem).
REQ-014 FSM states: IDLE, CALC, FIX.
REQ-015 IDLE transition: IDLE with start=1 at edge N → CALC; dividend/divisor captured at edge N; busy=1 from edge N.
REQ-016 CALC operation: one restoring shift/trial-subtract iteration per cycle on operand magnitudes; iteration counter 0..7; after edge N+8 → FIX.
REQ-017 Partial-remainder width: 5 bits unsigned, so |divisor|=8 is handled without loss.
REQ-018 FIX state: applies signs; at edge N+9 → IDLE; quot/rem/dz/ovf registered; done=1 and busy=0 for exactly cycle N+9..N+10; total latency 9 cycles.
REQ-019 Rounding and signs: quotient truncates toward zero; rem takes the dividend's sign, or is 0; |rem| < |divisor|.
REQ-020 Overflow: dividend=-128 with divisor=-1 gives quot=8'h80, rem=4'h0, ovf=1; ovf=0 for every other operand pair.
REQ-021 Start while busy: start is ignored in CALC and FIX; captured operands are unaffected.
REQ-022 Back-to-back operations: start may be accepted in the cycle done is high, because the FSM is then in IDLE.
REQ-023 Output hold: quot, rem, dz and ovf hold their values until the next completion or reset; done never asserts without a preceding accepted start.

Reset
REQ-024 Reset values: rst=1 forces IDLE asynchronously, with quot=8'h00, rem=4'h0, busy=0, done=0, dz=0, ovf=0, and counter and operand registers cleared.
REQ-025 Reset mid-operation: rst during CALC or FIX aborts the operation; no done pulse occurs for it; the first start after rst deasserts begins a fresh operation.

Configuration
REQ-026 Macro DIVZERO_CHECK_EN defined: start with divisor=0 in IDLE bypasses CALC.
  - Registers at edge N: quot=8'hFF, rem=4'h0, dz=1, ovf=0.
  - done=1 for cycle N..N+1; busy stays 0.
REQ-027 Macro DIVZERO_CHECK_EN undefined:
  - dz is tied to 0.
  - A zero divisor runs the normal 9-cycle sequence.
  - quot and rem are don't-care for that operation; done timing is unchanged.

Verification
REQ-028 Positive operands: dividend=8'd100, divisor=4'd7, start at edge N → done after edge N+9, quot=8'h0E, rem=4'h2, dz=0, ovf=0.
REQ-029 Negative dividend / negative divisor:
  - dividend=-100 (8'h9C), divisor=7 → quot=8'hF2, rem=4'hE.
  - dividend=100, divisor=-8 (4'h8) → quot=8'hF4, rem=4'h4.
REQ-030 Overflow case: dividend=8'h80, divisor=4'hF → quot=8'h80, rem=4'h0, ovf=1.
REQ-031 Divide by zero, DIVZERO_CHECK_EN defined: divisor=0, dividend=8'd37 → done after edge N, dz=1, quot=8'hFF, rem=4'h0.
REQ-032 Start while busy: second start pulse at edge N+3 with different operands → single done after edge N+9 with the first operation's results only.
REQ-033 Reset during CALC: rst asserted at cycle N+4 → busy=0 and all outputs 0 immediately; no done; a new start after release completes normally 9 cycles later.
